// File: rtl/fetch_if.sv
// Fetch-stage bus: instruction-memory port, redirect input and the
// valid/ready output entry towards decode.
interface fetch_if;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_pc_plus4;
    logic [31:0] out_instr;
    logic        out_fault;
    logic [1:0]  out_cause;
    logic [31:0] fetch_count;

    // Fetch stage side
    modport master (
        output imem_addr,
        input  imem_rdata,
        input  redirect_valid,
        input  redirect_pc,
        output out_valid,
        input  out_ready,
        output out_pc,
        output out_pc_plus4,
        output out_instr,
        output out_fault,
        output out_cause,
        output fetch_count
    );

    // Memory / redirect source / decode side
    modport slave (
        input  imem_addr,
        output imem_rdata,
        output redirect_valid,
        output redirect_pc,
        input  out_valid,
        output out_ready,
        input  out_pc,
        input  out_pc_plus4,
        input  out_instr,
        input  out_fault,
        input  out_cause,
        input  fetch_count
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch front end: owns the PC, presents it to instruction
// memory, captures the returned word into a one-entry output register
// with a valid/ready handshake, handles redirects and flags faults.
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_DEPTH = 256,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
    input  logic    clk,
    input  logic    rst_n,
    fetch_if.master bus
);
    typedef enum logic {RUN, HALT} state_t;

    localparam logic [29:0] DEPTH_WORDS = 30'(IMEM_DEPTH);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_pc_q, out_pc_d;
    logic [31:0] out_pc_plus4_q, out_pc_plus4_d;
    logic [31:0] out_instr_q, out_instr_d;
    logic        out_fault_q, out_fault_d;
    logic [1:0]  out_cause_q, out_cause_d;
    logic [31:0] fetch_count_q, fetch_count_d;

    logic        load;
    logic        handshake;
    logic        misaligned;
    logic        out_of_range;
    logic [31:0] pc_plus4;

    assign load         = !out_valid_q || bus.out_ready;
    assign handshake    = out_valid_q && bus.out_ready;
    assign misaligned   = (pc_q[1:0] != 2'b00);
    assign out_of_range = (pc_q[31:2] >= DEPTH_WORDS);
    assign pc_plus4     = pc_q + 32'd4;

    // Next-state: redirect beats fetch; a fault parks the PC and halts fetch
    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        out_valid_d    = out_valid_q;
        out_pc_d       = out_pc_q;
        out_pc_plus4_d = out_pc_plus4_q;
        out_instr_d    = out_instr_q;
        out_fault_d    = out_fault_q;
        out_cause_d    = out_cause_q;
        fetch_count_d  = fetch_count_q;

        if (bus.redirect_valid) begin
            // Flush wins over a same-cycle accept, so nothing is counted
            pc_d        = bus.redirect_pc;
            out_valid_d = 1'b0;
            state_d     = RUN;
        end else begin
            if (handshake) begin
                out_valid_d = 1'b0;
                if (!out_fault_q) begin
                    fetch_count_d = fetch_count_q + 32'd1;
                end
            end
            if (state_q == RUN && load) begin
                out_valid_d    = 1'b1;
                out_pc_d       = pc_q;
                out_pc_plus4_d = pc_plus4;
                if (misaligned || out_of_range) begin
                    out_instr_d = NOP_INSTR;
                    out_fault_d = 1'b1;
                    out_cause_d = misaligned ? 2'b01 : 2'b10;
                    state_d     = HALT;
                end else begin
                    out_instr_d = bus.imem_rdata;
                    out_fault_d = 1'b0;
                    out_cause_d = 2'b00;
                    pc_d        = pc_plus4;
                end
            end
        end
    end

    // State and output-entry registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= RUN;
            pc_q           <= RESET_PC;
            out_valid_q    <= 1'b0;
            out_pc_q       <= 32'd0;
            out_pc_plus4_q <= 32'd0;
            out_instr_q    <= NOP_INSTR;
            out_fault_q    <= 1'b0;
            out_cause_q    <= 2'b00;
            fetch_count_q  <= 32'd0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            out_valid_q    <= out_valid_d;
            out_pc_q       <= out_pc_d;
            out_pc_plus4_q <= out_pc_plus4_d;
            out_instr_q    <= out_instr_d;
            out_fault_q    <= out_fault_d;
            out_cause_q    <= out_cause_d;
            fetch_count_q  <= fetch_count_d;
        end
    end

    assign bus.imem_addr    = pc_q;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_pc       = out_pc_q;
    assign bus.out_pc_plus4 = out_pc_plus4_q;
    assign bus.out_instr    = out_instr_q;
    assign bus.out_fault    = out_fault_q;
    assign bus.out_cause    = out_cause_q;
    assign bus.fetch_count  = fetch_count_q;
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage. Memory model: word k holds k+1.
module tb_fetch_stage;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    fetch_if bus();

    fetch_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational instruction memory: mem[k] = k+1
    assign bus.imem_rdata = {2'b00, bus.imem_addr[31:2]} + 32'd1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_entry(input string tag, input logic [31:0] pc,
                               input logic [31:0] instr, input logic [31:0] cnt);
        check({tag, ".valid"}, {31'd0, bus.out_valid}, 32'd1);
        check({tag, ".pc"}, bus.out_pc, pc);
        check({tag, ".pc4"}, bus.out_pc_plus4, pc + 32'd4);
        check({tag, ".instr"}, bus.out_instr, instr);
        check({tag, ".fault"}, {31'd0, bus.out_fault}, 32'd0);
        check({tag, ".count"}, bus.fetch_count, cnt);
    endtask

    task automatic redirect(input logic [31:0] target);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = target;
        step();
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'd0;
        check("redir.valid", {31'd0, bus.out_valid}, 32'd0);
        check("redir.addr", bus.imem_addr, target);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n              = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'd0;
        bus.out_ready      = 1'b1;
        step();
        step();

        // Reset state
        check("rst.valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst.pc", bus.out_pc, 32'd0);
        check("rst.pc4", bus.out_pc_plus4, 32'd0);
        check("rst.instr", bus.out_instr, 32'h13);
        check("rst.fault", {31'd0, bus.out_fault}, 32'd0);
        check("rst.cause", {30'd0, bus.out_cause}, 32'd0);
        check("rst.count", bus.fetch_count, 32'd0);
        check("rst.addr", bus.imem_addr, 32'd0);

        // 1: streaming fetch with out_ready=1
        rst_n = 1'b1;
        step(); check_entry("t1.e0", 32'h0, 32'd1, 32'd0);
        step(); check_entry("t1.e1", 32'h4, 32'd2, 32'd1);
        step(); check_entry("t1.e2", 32'h8, 32'd3, 32'd2);

        // 2: backpressure holds entry 0x8 and the fetch address
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_entry("t2.hold", 32'h8, 32'd3, 32'd2);
            check("t2.addr", bus.imem_addr, 32'hC);
        end
        bus.out_ready = 1'b1;
        step(); check_entry("t2.e3", 32'hC, 32'd4, 32'd3);
        step(); check_entry("t2.e4", 32'h10, 32'd5, 32'd4);

        // 3: redirect flushes 0x10 even though out_ready=1
        redirect(32'h40);
        check("t3.count", bus.fetch_count, 32'd4);
        step(); check_entry("t3.e0", 32'h40, 32'h11, 32'd4);
        step(); check_entry("t3.e1", 32'h44, 32'h12, 32'd5);

        // 4: misaligned target faults, halts, then redirect resumes
        redirect(32'h22);
        step();
        check("t4.valid", {31'd0, bus.out_valid}, 32'd1);
        check("t4.pc", bus.out_pc, 32'h22);
        check("t4.pc4", bus.out_pc_plus4, 32'h26);
        check("t4.instr", bus.out_instr, 32'h13);
        check("t4.fault", {31'd0, bus.out_fault}, 32'd1);
        check("t4.cause", {30'd0, bus.out_cause}, 32'd1);
        check("t4.count", bus.fetch_count, 32'd5);
        step();
        check("t4.halt.valid", {31'd0, bus.out_valid}, 32'd0);
        check("t4.halt.count", bus.fetch_count, 32'd5);
        step();
        check("t4.halt2.valid", {31'd0, bus.out_valid}, 32'd0);
        check("t4.halt2.addr", bus.imem_addr, 32'h22);
        redirect(32'h0);
        step(); check_entry("t4.r0", 32'h0, 32'd1, 32'd5);
        step(); check_entry("t4.r1", 32'h4, 32'd2, 32'd6);

        // 5: run off the end of memory
        redirect(32'h3F8);
        step(); check_entry("t5.e0", 32'h3F8, 32'hFF, 32'd6);
        step(); check_entry("t5.e1", 32'h3FC, 32'h100, 32'd7);
        step();
        check("t5.pc", bus.out_pc, 32'h400);
        check("t5.fault", {31'd0, bus.out_fault}, 32'd1);
        check("t5.cause", {30'd0, bus.out_cause}, 32'd2);
        check("t5.instr", bus.out_instr, 32'h13);
        check("t5.count", bus.fetch_count, 32'd8);
        check("t5.addr", bus.imem_addr, 32'h400);
        step();
        check("t5.halt.valid", {31'd0, bus.out_valid}, 32'd0);
        check("t5.halt.addr", bus.imem_addr, 32'h400);
        check("t5.halt.count", bus.fetch_count, 32'd8);

        // Top-of-address-space target: out-of-range, pc+4 wraps to 0
        redirect(32'hFFFF_FFFC);
        step();
        check("wrap.pc", bus.out_pc, 32'hFFFF_FFFC);
        check("wrap.pc4", bus.out_pc_plus4, 32'h0);
        check("wrap.cause", {30'd0, bus.out_cause}, 32'd2);
        check("wrap.fault", {31'd0, bus.out_fault}, 32'd1);

        // 6: reset together with redirect mid-stream
        redirect(32'h0);
        step(); check_entry("t6.e0", 32'h0, 32'd1, 32'd8);
        step(); check_entry("t6.e1", 32'h4, 32'd2, 32'd9);
        rst_n              = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h80;
        step();
        check("t6.valid", {31'd0, bus.out_valid}, 32'd0);
        check("t6.addr", bus.imem_addr, 32'h0);
        check("t6.count", bus.fetch_count, 32'd0);
        check("t6.instr", bus.out_instr, 32'h13);
        rst_n              = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'd0;
        step(); check_entry("t6.post", 32'h0, 32'd1, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
